// File: rtl/mux_arb_pkg.sv
// Shared types and helpers for the mux81 round-robin arbiter.
package mux_arb_pkg;

    localparam int N_REQ = 8;
    localparam int SEL_W = 3;

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    function automatic logic [SEL_W-1:0] oh2bin(input logic [N_REQ-1:0] oh);
        logic [SEL_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (oh[i]) begin
                idx = idx | SEL_W'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/mux8_rr_arbiter_rr_pick.sv
// Combinational round-robin picker: first masked request after 'last'.
module rr_pick
    import mux_arb_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [SEL_W-1:0] last,
    input  logic [N_REQ-1:0] mask,
    output logic             any,
    output logic [N_REQ-1:0] win_oh,
    output logic [SEL_W-1:0] win_idx
);

    logic [N_REQ-1:0] cand;
    logic [SEL_W-1:0] idx;
    logic             found;

    always_comb begin
        cand    = req & mask;
        win_oh  = '0;
        win_idx = '0;
        found   = 1'b0;
        idx     = '0;
        // 3-bit addition wraps 7->0, so k=8 lands back on 'last' itself
        for (int k = 1; k <= N_REQ; k++) begin
            idx = last + SEL_W'(k);
            if (!found && cand[idx]) begin
                found       = 1'b1;
                win_oh[idx] = 1'b1;
                win_idx     = idx;
            end
        end
        any = found;
    end

endmodule

// File: rtl/mux8_rr_arbiter.sv
// Round-robin owner arbiter driving mux81.sel for 8 requesters.
// Define ARB_TIMEOUT_EN to force rotation after HOLD_MAX held cycles.
module mux8_rr_arbiter
    import mux_arb_pkg::*;
#(
    parameter int HOLD_MAX = 16,
    parameter int CNT_W    = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] gnt,
    output logic [SEL_W-1:0] sel,
    output logic             gnt_valid,
    output logic             preempt
);

    if (2**CNT_W <= HOLD_MAX) begin : g_cfg_err
        $error("CNT_W too narrow for HOLD_MAX");
    end

    state_t           state, state_nx;
    logic [N_REQ-1:0] gnt_nx;
    logic [SEL_W-1:0] sel_nx;
    logic [SEL_W-1:0] last, last_nx;
    logic [N_REQ-1:0] mask;
    logic             any;
    logic [N_REQ-1:0] win_oh;
    logic [SEL_W-1:0] win_idx;
    logic             owner_req;
    logic             expire;

    // While granted, the owner is excluded so 'any' means "someone else waits"
    assign mask      = (state == GRANT) ? ~gnt : '1;
    assign owner_req = |(req & gnt);
    assign gnt_valid = |gnt;

    rr_pick u_pick (
        .req     (req),
        .last    (last),
        .mask    (mask),
        .any     (any),
        .win_oh  (win_oh),
        .win_idx (win_idx)
    );

`ifdef ARB_TIMEOUT_EN
    logic [CNT_W-1:0] hold_cnt;
    logic             hold;

    assign expire = (hold_cnt == CNT_W'(HOLD_MAX - 1)) && any;
    assign hold   = (state == GRANT) && owner_req && !expire;

    // Saturates at HOLD_MAX-1 so a late competitor still triggers rotation
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt <= '0;
            preempt  <= 1'b0;
        end else begin
            preempt <= (state == GRANT) && owner_req && expire;
            if (!hold) begin
                hold_cnt <= '0;
            end else if (hold_cnt != CNT_W'(HOLD_MAX - 1)) begin
                hold_cnt <= hold_cnt + 1'b1;
            end
        end
    end
`else
    assign expire  = 1'b0;
    assign preempt = 1'b0;
`endif

    always_comb begin
        state_nx = state;
        gnt_nx   = gnt;
        sel_nx   = sel;
        last_nx  = last;
        unique case (state)
            IDLE: begin
                if (any) begin
                    state_nx = GRANT;
                    gnt_nx   = win_oh;
                    sel_nx   = win_idx;
                    last_nx  = win_idx;
                end
            end
            GRANT: begin
                if (owner_req && !expire) begin
                    gnt_nx = gnt;
                end else if (any) begin
                    gnt_nx  = win_oh;
                    sel_nx  = win_idx;
                    last_nx = win_idx;
                end else begin
                    state_nx = IDLE;
                    gnt_nx   = '0;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            gnt   <= '0;
            sel   <= '0;
            last  <= SEL_W'(N_REQ - 1);
        end else begin
            state <= state_nx;
            gnt   <= gnt_nx;
            sel   <= sel_nx;
            last  <= last_nx;
        end
    end

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// Scoreboard bench for mux8_rr_arbiter; honours ARB_TIMEOUT_EN.
module tb_mux8_rr_arbiter;
    import mux_arb_pkg::*;

    localparam int HOLD_MAX = 16;
`ifdef ARB_TIMEOUT_EN
    localparam int HOLD_CYC = 12;
`else
    localparam int HOLD_CYC = 20;
`endif

    typedef struct packed {
        logic [7:0] gnt;
        logic [2:0] sel;
        logic       valid;
        logic       pre;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] req = 8'h00;
    logic [7:0] gnt;
    logic [2:0] sel;
    logic       gnt_valid;
    logic       preempt;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    logic [7:0] m_gnt;
    logic [2:0] m_sel;
    logic [2:0] m_last;
    int         m_cnt;

    always #5 clk = ~clk;

    mux8_rr_arbiter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .gnt       (gnt),
        .sel       (sel),
        .gnt_valid (gnt_valid),
        .preempt   (preempt)
    );

    task automatic model_reset();
        m_gnt  = 8'h00;
        m_sel  = 3'd0;
        m_last = 3'd7;
        m_cnt  = 0;
        sb.delete();
    endtask

    // Reference: predicts the registered outputs after the next edge
    task automatic model_step(input logic [7:0] r);
        exp_t e;
        bit   keep;
        bit   force_rot;
        int   w;
        keep      = (m_gnt != 8'h00) && r[m_sel];
        force_rot = 1'b0;
`ifdef ARB_TIMEOUT_EN
        if (keep && m_cnt == HOLD_MAX - 1 && (r & ~m_gnt) != 8'h00) begin
            keep      = 1'b0;
            force_rot = 1'b1;
        end
`endif
        if (keep) begin
            if (m_cnt < HOLD_MAX - 1) m_cnt++;
        end else begin
            w = -1;
            for (int k = 1; k <= 8; k++) begin
                int i;
                i = (int'(m_last) + k) % 8;
                if (w < 0 && r[i] && !m_gnt[i]) w = i;
            end
            m_cnt = 0;
            if (w >= 0) begin
                m_gnt  = 8'h01 << w;
                m_sel  = 3'(w);
                m_last = 3'(w);
            end else begin
                m_gnt = 8'h00;
                force_rot = 1'b0;
            end
        end
        e.gnt   = m_gnt;
        e.sel   = m_sel;
        e.valid = (m_gnt != 8'h00);
        e.pre   = force_rot;
        sb.push_back(e);
    endtask

    task automatic sb_cycle(input logic [7:0] r);
        exp_t e;
        req = r;
        model_step(r);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        n_cmp++;
        if ({gnt, sel, gnt_valid, preempt} !== e) begin
            n_bad++;
            $display("FAIL sb req=%h got gnt=%h sel=%0d v=%b p=%b want gnt=%h sel=%0d v=%b p=%b",
                     r, gnt, sel, gnt_valid, preempt, e.gnt, e.sel, e.valid, e.pre);
        end
        n_cmp++;
        if (($countones(gnt) > 1) || (gnt_valid && sel !== oh2bin(gnt))) begin
            n_bad++;
            $display("FAIL invariant got gnt=%h sel=%0d v=%b want onehot, sel=oh2bin",
                     gnt, sel, gnt_valid);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req   = 8'hFF;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if ({gnt, sel, gnt_valid, preempt} !== 13'h0) begin
            n_bad++;
            $display("FAIL reset_hold got gnt=%h sel=%0d v=%b p=%b want 0",
                     gnt, sel, gnt_valid, preempt);
        end
        rst_n = 1'b1;
        model_reset();
        sb_cycle(8'hFF);
        n_cmp++;
        if (gnt !== 8'h01 || sel !== 3'd0) begin
            n_bad++;
            $display("FAIL reset_first got gnt=%h sel=%0d want 01/0", gnt, sel);
        end
    endtask

    task automatic test_rotation();
        logic [2:0] exp_s;
        exp_s = 3'd0;
        for (int k = 0; k < 8; k++) begin
            sb_cycle(8'hFF & ~(8'h01 << exp_s));
            exp_s = exp_s + 3'd1;
            n_cmp++;
            if (sel !== exp_s || gnt_valid !== 1'b1) begin
                n_bad++;
                $display("FAIL rotation got sel=%0d v=%b want sel=%0d v=1",
                         sel, gnt_valid, exp_s);
            end
        end
    endtask

    task automatic test_hold();
        for (int i = 0; i < HOLD_CYC; i++) begin
            sb_cycle(8'h05);
            n_cmp++;
            if (gnt !== 8'h01) begin
                n_bad++;
                $display("FAIL hold cyc%0d got gnt=%h want 01", i, gnt);
            end
        end
        sb_cycle(8'h04);
        n_cmp++;
        if (gnt !== 8'h04 || sel !== 3'd2) begin
            n_bad++;
            $display("FAIL hold_release got gnt=%h sel=%0d want 04/2", gnt, sel);
        end
    endtask

    task automatic test_idle_return();
        sb_cycle(8'h00);
        n_cmp++;
        if (gnt !== 8'h00 || gnt_valid !== 1'b0 || sel !== 3'd2) begin
            n_bad++;
            $display("FAIL idle_enter got gnt=%h v=%b sel=%0d want 00/0/2",
                     gnt, gnt_valid, sel);
        end
        for (int i = 0; i < 3; i++) begin
            sb_cycle(8'h20);
            n_cmp++;
            if (gnt !== 8'h20) begin
                n_bad++;
                $display("FAIL idle_pulse cyc%0d got gnt=%h want 20", i, gnt);
            end
        end
        for (int i = 0; i < 2; i++) begin
            sb_cycle(8'h00);
            n_cmp++;
            if (gnt !== 8'h00 || gnt_valid !== 1'b0 || sel !== 3'd5) begin
                n_bad++;
                $display("FAIL idle_after got gnt=%h v=%b sel=%0d want 00/0/5",
                         gnt, gnt_valid, sel);
            end
        end
    endtask

    task automatic test_timeout();
        sb_cycle(8'h08);
        n_cmp++;
        if (gnt !== 8'h08) begin
            n_bad++;
            $display("FAIL to_grant got gnt=%h want 08", gnt);
        end
`ifdef ARB_TIMEOUT_EN
        for (int i = 1; i < HOLD_MAX; i++) begin
            sb_cycle(8'h48);
            n_cmp++;
            if (gnt !== 8'h08 || preempt !== 1'b0) begin
                n_bad++;
                $display("FAIL to_hold cyc%0d got gnt=%h p=%b want 08/0", i, gnt, preempt);
            end
        end
        sb_cycle(8'h48);
        n_cmp++;
        if (gnt !== 8'h40 || preempt !== 1'b1) begin
            n_bad++;
            $display("FAIL to_preempt got gnt=%h p=%b want 40/1", gnt, preempt);
        end
        sb_cycle(8'h48);
        n_cmp++;
        if (gnt !== 8'h40 || preempt !== 1'b0) begin
            n_bad++;
            $display("FAIL to_pulse got gnt=%h p=%b want 40/0", gnt, preempt);
        end
        for (int i = 0; i < 20; i++) begin
            sb_cycle(8'h40);
            n_cmp++;
            if (gnt !== 8'h40 || preempt !== 1'b0) begin
                n_bad++;
                $display("FAIL to_alone cyc%0d got gnt=%h p=%b want 40/0", i, gnt, preempt);
            end
        end
`else
        for (int i = 0; i < 20; i++) begin
            sb_cycle(8'h48);
            n_cmp++;
            if (gnt !== 8'h08 || preempt !== 1'b0) begin
                n_bad++;
                $display("FAIL no_timeout cyc%0d got gnt=%h p=%b want 08/0", i, gnt, preempt);
            end
        end
`endif
        sb_cycle(8'h00);
    endtask

    task automatic test_async_reset();
        sb_cycle(8'h10);
        n_cmp++;
        if (sel !== 3'd4 || gnt !== 8'h10) begin
            n_bad++;
            $display("FAIL ar_setup got gnt=%h sel=%0d want 10/4", gnt, sel);
        end
        sb_cycle(8'h10);
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({gnt, sel, gnt_valid, preempt} !== 13'h0) begin
            n_bad++;
            $display("FAIL ar_async got gnt=%h sel=%0d v=%b p=%b want 0",
                     gnt, sel, gnt_valid, preempt);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        sb_cycle(8'hFF);
        n_cmp++;
        if (gnt !== 8'h01 || sel !== 3'd0) begin
            n_bad++;
            $display("FAIL ar_restart got gnt=%h sel=%0d want 01/0", gnt, sel);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 200; i++) begin
            sb_cycle(8'($urandom) & 8'($urandom));
        end
    endtask

    initial begin
        test_reset();
        test_rotation();
        test_hold();
        test_idle_return();
        test_timeout();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
